// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pop-side burst master for the fifo push/pop interface.
// Reads exactly `len` words and presents them on a valid/ready stream. A
// 3-entry skid buffer covers the fifo's one-cycle read latency so the burst
// can run at one word per cycle. fifo_pop depends only on registered state and
// fifo_empty, never on m_ready.
module fifo_burst_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  logic             fifo_error,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_pop,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [LEN_W-1:0] words_read,
    output logic             err_sticky
);

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [LEN_W-1:0] r_remaining, w_remaining_d;
    logic [LEN_W-1:0] r_words_read, w_words_read_d;
    logic             r_err, w_err_d;
    logic             r_in_flight;
    logic [1:0]       r_occ, w_occ_d;
    logic [WIDTH-1:0] r_buf [3];
    logic [WIDTH-1:0] w_buf_d [3];

    logic             w_pop;
    logic             w_xfer;
    logic             w_cap;
    logic             w_busy;
    logic [2:0]       w_pending;
    logic [1:0]       w_wr_idx;

    // Buffered plus in-flight words; a new pop must still fit in 3 entries.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_in_flight};
    assign w_pop     = (r_state == StRead) && !fifo_empty && (r_remaining != '0) &&
                       (w_pending <= 3'd2);
    assign w_xfer    = (r_occ != 2'd0) && m_ready;
    assign w_cap     = r_in_flight;
    // Capture lands behind the surviving entries after any same-cycle shift.
    assign w_wr_idx  = r_occ - {1'b0, w_xfer};
    assign w_busy    = (r_state == StRead) || (r_state == StFlush);

    assign busy       = w_busy;
    assign done       = (r_state == StDone);
    assign fifo_pop   = w_pop;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[0];
    assign words_read = r_words_read;
    assign err_sticky = r_err;

    // Next-state logic for the burst FSM and its counters.
    always_comb begin
        w_state_d      = r_state;
        w_remaining_d  = r_remaining;
        w_words_read_d = r_words_read;
        w_err_d        = r_err;

        if (w_xfer) begin
            w_words_read_d = r_words_read + LEN_W'(1);
        end
        if (w_busy && fifo_error) begin
            w_err_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_words_read_d = '0;
                    w_err_d        = 1'b0;
                    if (len != '0) begin
                        w_state_d     = StRead;
                        w_remaining_d = len;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StRead: begin
                if (w_pop) begin
                    w_remaining_d = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!r_in_flight && (r_occ == 2'd0)) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Skid buffer next state: shift out on transfer, append on capture.
    always_comb begin
        w_buf_d = r_buf;
        w_occ_d = r_occ;

        if (w_xfer) begin
            w_buf_d[0] = r_buf[1];
            w_buf_d[1] = r_buf[2];
        end
        if (w_cap) begin
            for (int i = 0; i < 3; i++) begin
                if (w_wr_idx == 2'(i)) begin
                    w_buf_d[i] = fifo_data_out;
                end
            end
        end

        case ({w_cap, w_xfer})
            2'b10:   w_occ_d = r_occ + 2'd1;
            2'b01:   w_occ_d = r_occ - 2'd1;
            default: w_occ_d = r_occ;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_remaining  <= '0;
            r_words_read <= '0;
            r_err        <= 1'b0;
            r_in_flight  <= 1'b0;
            r_occ        <= 2'd0;
        end else begin
            r_state      <= w_state_d;
            r_remaining  <= w_remaining_d;
            r_words_read <= w_words_read_d;
            r_err        <= w_err_d;
            r_in_flight  <= w_pop;
            r_occ        <= w_occ_d;
        end
    end

    // Skid buffer data registers; cleared so m_data reads 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_buf <= w_buf_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small behavioural fifo.
module tb_fifo_burst_reader;

    localparam int W  = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic          fifo_error;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_pop;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic [LW-1:0] words_read;
    logic          err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural fifo: one-cycle read latency.
    logic [W-1:0] fmem [64];
    int wp = 0;
    int rp = 0;
    int cyc = 0;

    // Monitor logs.
    int n_pop = 0;
    int n_xfer = 0;
    int n_done = 0;
    int bad_pop = 0;
    int done_cyc = 0;
    int pop_cyc [64];
    int xfer_cyc [128];
    logic [W-1:0] xfer_data [128];
    int start_cyc = 0;

    fifo_burst_reader #(
        .WIDTH(W),
        .LEN_W(LW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .fifo_empty   (fifo_empty),
        .fifo_error   (fifo_error),
        .fifo_data_out(fifo_data_out),
        .fifo_pop     (fifo_pop),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .words_read   (words_read),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // Fifo read side and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_pop) begin
            fifo_data_out <= fmem[rp];
            rp <= rp + 1;
        end
    end

    // Log pops, transfers and done pulses mid-cycle.
    always @(negedge clk) begin
        if (fifo_pop) begin
            pop_cyc[n_pop] <= cyc;
            n_pop <= n_pop + 1;
            if (fifo_empty) bad_pop <= bad_pop + 1;
        end
        if (m_valid && m_ready) begin
            xfer_data[n_xfer] <= m_data;
            xfer_cyc[n_xfer] <= cyc;
            n_xfer <= n_xfer + 1;
        end
        if (done) begin
            n_done <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        fmem[wp] = d;
        wp = wp + 1;
    endtask

    task automatic do_start(input logic [LW-1:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        len = l;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pop"}, 32'(fifo_pop), 32'd0);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
        chk({tag, "_mdata"}, m_data, 32'd0);
        chk({tag, "_words"}, 32'(words_read), 32'd0);
        chk({tag, "_err"}, 32'(err_sticky), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bp, bx, bd;
        reset_n = 1'b0;
        start = 1'b0;
        len = '0;
        fifo_error = 1'b0;
        m_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        #11;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst A..D, no back-pressure.
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        m_ready = 1'b1;
        bp = n_pop; bx = n_xfer; bd = n_done;
        do_start(8'd4);
        wait_done("t1_done", 40);
        @(negedge clk);
        chk("t1_words_read", 32'(words_read), 32'd4);
        chk("t1_pops", 32'(n_pop - bp), 32'd4);
        chk("t1_xfers", 32'(n_xfer - bx), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_data", xfer_data[bx + i], 32'hA + 32'(i));
        chk("t1_first_pop_lat", 32'(pop_cyc[bp] - start_cyc), 32'd1);
        chk("t1_pops_back2back", 32'(pop_cyc[bp + 3] - pop_cyc[bp]), 32'd3);
        chk("t1_first_xfer_lat", 32'(xfer_cyc[bx] - start_cyc), 32'd3);
        chk("t1_xfers_back2back", 32'(xfer_cyc[bx + 3] - xfer_cyc[bx]), 32'd3);
        chk("t1_done_after_last", 32'(done_cyc - xfer_cyc[bx + 3]), 32'd2);
        chk("t1_done_count", 32'(n_done - bd), 32'd1);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Back-pressure: 6 words held off for 10 cycles.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h10 + 32'(i));
        bp = n_pop; bx = n_xfer; bd = n_done;
        do_start(8'd6);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(m_valid), 32'd1);
            chk("t2_hold_data", m_data, 32'h10);
        end
        chk("t2_pops_stalled", 32'(n_pop - bp), 32'd3);
        chk("t2_pop_low", 32'(fifo_pop), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done("t2_done", 60);
        @(negedge clk);
        chk("t2_xfers", 32'(n_xfer - bx), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_data", xfer_data[bx + i], 32'h10 + 32'(i));
        chk("t2_words_read", 32'(words_read), 32'd6);
        chk("t2_done_count", 32'(n_done - bd), 32'd1);

        // Fifo runs dry mid-burst, refilled later.
        push(32'h20); push(32'h21);
        bx = n_xfer; bd = n_done;
        do_start(8'd5);
        repeat (8) @(negedge clk);
        chk("t3_busy_stalled", 32'(busy), 32'd1);
        chk("t3_words_partial", 32'(words_read), 32'd2);
        chk("t3_pop_when_empty", 32'(fifo_pop), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push(32'h22 + 32'(i));
        end
        wait_done("t3_done", 60);
        @(negedge clk);
        chk("t3_xfers", 32'(n_xfer - bx), 32'd5);
        for (int i = 0; i < 5; i++) chk("t3_data", xfer_data[bx + i], 32'h20 + 32'(i));
        chk("t3_words_read", 32'(words_read), 32'd5);
        chk("t3_done_count", 32'(n_done - bd), 32'd1);
        chk("t3_no_empty_pop", 32'(bad_pop), 32'd0);

        // Zero-length start.
        bp = n_pop;
        do_start(8'd0);
        @(negedge clk);
        chk("t4_zero_done", 32'(done), 32'd1);
        chk("t4_zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_zero_done_once", 32'(done), 32'd0);
        chk("t4_zero_pops", 32'(n_pop - bp), 32'd0);
        chk("t4_zero_words", 32'(words_read), 32'd0);

        // Start while busy is ignored.
        push(32'h30); push(32'h31); push(32'h32);
        bp = n_pop; bd = n_done;
        do_start(8'd3);
        do_start(8'd7);
        wait_done("t4_done", 40);
        @(negedge clk);
        chk("t4_words_read", 32'(words_read), 32'd3);
        chk("t4_pops", 32'(n_pop - bp), 32'd3);
        repeat (3) @(negedge clk);
        chk("t4_stays_idle", 32'(busy), 32'd0);
        chk("t4_done_count", 32'(n_done - bd), 32'd1);

        // Error flag: ignored when idle, sticky while busy.
        @(posedge clk);
        #1;
        fifo_error = 1'b1;
        @(posedge clk);
        #1;
        fifo_error = 1'b0;
        @(negedge clk);
        chk("t5_idle_err", 32'(err_sticky), 32'd0);
        for (int i = 0; i < 4; i++) push(32'h40 + 32'(i));
        m_ready = 1'b0;
        do_start(8'd4);
        repeat (2) @(negedge clk);
        chk("t5_err_before", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;
        fifo_error = 1'b1;
        @(posedge clk);
        #1;
        fifo_error = 1'b0;
        @(negedge clk);
        chk("t5_err_set", 32'(err_sticky), 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done("t5_done", 60);
        @(negedge clk);
        chk("t5_err_held", 32'(err_sticky), 32'd1);
        chk("t5_words_read", 32'(words_read), 32'd4);
        do_start(8'd0);
        @(negedge clk);
        chk("t5_err_cleared", 32'(err_sticky), 32'd0);

        // Reset mid-burst with two words buffered.
        for (int i = 0; i < 4; i++) push(32'h50 + 32'(i));
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        do_start(8'd4);
        @(posedge clk);
        #1;
        fifo_error = 1'b1;
        @(posedge clk);
        #1;
        fifo_error = 1'b0;
        @(negedge clk);
        chk("t6_valid_before", 32'(m_valid), 32'd1);
        chk("t6_err_before", 32'(err_sticky), 32'd1);
        bd = n_done;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_idle_busy", 32'(busy), 32'd0);
            chk("t6_idle_done", 32'(done), 32'd0);
            chk("t6_idle_pop", 32'(fifo_pop), 32'd0);
        end
        chk("t6_no_done", 32'(n_done - bd), 32'd0);
        chk("final_no_empty_pop", 32'(bad_pop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
